// File: rtl/mem_arbiter_if.sv
// Requester-side memory bus shared by the core port and the loader/debug port.
// The master drives the request; the arbiter (slave) returns ready and read data.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory, one access in flight.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate on contention instead of fixed port-0 priority.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      m0,
    mem_arbiter_if.slave      m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int                 CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_any;
    logic              w_win;
    logic              w_rdy0;
    logic              w_rdy1;
    logic [DATA_W-1:0] w_rdata0;
    logic [DATA_W-1:0] w_rdata1;

    assign w_any = m0.req | m1.req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention the port that did not win last time goes next.
    assign w_win = m0.req ? (m1.req ? ~r_last_grant : 1'b0) : 1'b1;
`else
    assign w_win = ~m0.req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                        r_we         <= w_win ? m1.we : m0.we;
                    end
                end
                ACCESS: begin
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                DONE: begin
                    if (!r_we) begin
                        if (r_grant) r_rdata1 <= mem_rdata;
                        else         r_rdata0 <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ACCESS;
            ACCESS:  if (r_cnt == CNT_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read data is forwarded straight from memory in DONE so it is valid with ready,
    // and the captured copy holds it afterwards.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_rdy0    = 1'b0;
        w_rdy1    = 1'b0;
        w_rdata0  = r_rdata0;
        w_rdata1  = r_rdata1;
        case (r_state)
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = r_we && (r_cnt == '0);
                mem_addr  = r_grant ? m1.addr  : m0.addr;
                mem_wdata = r_grant ? m1.wdata : m0.wdata;
            end
            DONE: begin
                if (r_grant) begin
                    w_rdy1 = 1'b1;
                    if (!r_we) w_rdata1 = mem_rdata;
                end else begin
                    w_rdy0 = 1'b1;
                    if (!r_we) w_rdata0 = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign m0.ready = w_rdy0;
    assign m1.ready = w_rdy1;
    assign m0.rdata = w_rdata0;
    assign m1.rdata = w_rdata1;
endmodule
